// File: rtl/tile_table_writer.sv
// Command-driven write port for the tile table RAM: single writes, table/row/column fills.
// Optional power-up clear of the whole table under TILE_WRITER_CLEAR_ON_RESET_EN.
module tile_table_writer #(
    parameter int unsigned ROWS       = 30,
    parameter int unsigned COLS       = 40,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] BLANK_TILE = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [4:0]            cmd_row,
    input  logic [5:0]            cmd_col,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  write_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0]  TOTAL  = CNT_WIDTH'(ROWS * COLS);
    localparam logic [ADDR_WIDTH-1:0] COLS_A = ADDR_WIDTH'(COLS);
    localparam logic [CNT_WIDTH-1:0]  CNT_1  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_2  = CNT_WIDTH'(2);

    typedef enum logic [1:0] {
        OP_SINGLE = 2'b00,
        OP_FILL   = 2'b01,
        OP_ROW    = 2'b10,
        OP_COL    = 2'b11
    } op_t;

`ifdef TILE_WRITER_CLEAR_ON_RESET_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CLEAR} state_t;
`else
    typedef enum logic {S_IDLE, S_RUN} state_t;
`endif

    state_t                state, state_d;
    logic [ADDR_WIDTH-1:0] stride, stride_d, waddr_d;
    logic [CNT_WIDTH-1:0]  remaining, remaining_d;
    logic [DATA_WIDTH-1:0] din_d;
    logic                  write_en_d, done_d, err_d, cmd_ready_d, busy_d;

    logic [ADDR_WIDTH-1:0] row_base, start_addr, start_stride;
    logic [CNT_WIDTH-1:0]  start_cnt;
    logic                  row_oor, col_oor, start_oor;

    // Decode of the presented command; only consumed on acceptance.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        row_base     = ADDR_WIDTH'(cmd_row) * COLS_A;
        row_oor      = 32'(cmd_row) >= ROWS;
        col_oor      = 32'(cmd_col) >= COLS;
        start_addr   = '0;
        start_stride = ADDR_WIDTH'(1);
        start_cnt    = CNT_1;
        start_oor    = 1'b0;
        case (op_t'(cmd_op))
            OP_SINGLE: begin
                start_oor  = row_oor || col_oor;
                start_addr = row_base + ADDR_WIDTH'(cmd_col);
            end
            OP_FILL: begin
                start_cnt = TOTAL;
            end
            OP_ROW: begin
                start_oor  = row_oor;
                start_addr = row_base;
                start_cnt  = CNT_WIDTH'(COLS);
            end
            OP_COL: begin
                start_oor    = col_oor;
                start_addr   = ADDR_WIDTH'(cmd_col);
                start_stride = COLS_A;
                start_cnt    = CNT_WIDTH'(ROWS);
            end
        endcase
    end

    always_comb begin
        state_d     = state;
        waddr_d     = waddr;
        din_d       = din;
        stride_d    = stride;
        remaining_d = remaining;
        write_en_d  = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (start_oor) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = S_RUN;
                        waddr_d     = start_addr;
                        din_d       = cmd_data;
                        stride_d    = start_stride;
                        remaining_d = start_cnt;
                        write_en_d  = 1'b1;
                        done_d      = (start_cnt == CNT_1);
                    end
                end
            end
            S_RUN: begin
                // remaining counts the write currently on the port.
                if (remaining == CNT_1) begin
                    state_d = S_IDLE;
                    din_d   = BLANK_TILE;
                end else begin
                    write_en_d  = 1'b1;
                    waddr_d     = waddr + stride;
                    remaining_d = remaining - CNT_1;
                    done_d      = (remaining == CNT_2);
                end
            end
`ifdef TILE_WRITER_CLEAR_ON_RESET_EN
            S_CLEAR: begin
                din_d = BLANK_TILE;
                if (!write_en) begin
                    write_en_d = 1'b1;
                end else if (remaining == CNT_1) begin
                    state_d = S_IDLE;
                end else begin
                    write_en_d  = 1'b1;
                    waddr_d     = waddr + ADDR_WIDTH'(1);
                    remaining_d = remaining - CNT_1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rstn) begin
            waddr    <= '0;
            din      <= '0;
            write_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            stride   <= ADDR_WIDTH'(1);
`ifdef TILE_WRITER_CLEAR_ON_RESET_EN
            state     <= S_CLEAR;
            cmd_ready <= 1'b0;
            remaining <= TOTAL;
`else
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            remaining <= '0;
`endif
        end else begin
            state     <= state_d;
            waddr     <= waddr_d;
            din       <= din_d;
            write_en  <= write_en_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
            cmd_ready <= cmd_ready_d;
            stride    <= stride_d;
            remaining <= remaining_d;
        end
    end

endmodule

// File: tb/tb_tile_table_writer.sv
// Randomized bench for tile_table_writer: queue-based write model compared every cycle,
// plus literal expectations from the directed scenarios.
module tb_tile_table_writer;

    localparam int ROWS = 30;
    localparam int COLS = 40;
    localparam int AW   = 11;
    localparam int DW   = 8;
    localparam logic [DW-1:0] BLANK = 8'h00;
`ifdef TILE_WRITER_CLEAR_ON_RESET_EN
    localparam logic RST_READY = 1'b0;
`else
    localparam logic RST_READY = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [4:0]    cmd_row;
    logic [5:0]    cmd_col;
    logic [DW-1:0] cmd_data;
    logic [AW-1:0] waddr;
    logic [DW-1:0] din;
    logic          write_en, busy, done, err;

    tile_table_writer #(
        .ROWS(ROWS), .COLS(COLS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLANK_TILE(BLANK)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_data(cmd_data),
        .waddr(waddr), .din(din), .write_en(write_en),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of the writes still to appear on the port, one per cycle.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } wr_t;

    wr_t q[$];
    logic          exp_we, exp_done, exp_err, exp_ready, exp_busy, in_reset;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din;
    bit            model_on = 1'b0;
    int            acc_cnt  = 0;
    int            m_r, m_c;

    function automatic wr_t mk(input int a, input logic [DW-1:0] d, input bit last);
        wr_t w;
        w.addr = AW'(a);
        w.data = d;
        w.last = last;
        return w;
    endfunction

    always @(posedge clk) begin
        in_reset = !rstn;
        if (!rstn) begin
            q.delete();
            exp_we = 0; exp_addr = '0; exp_din = '0;
            exp_done = 0; exp_err = 0; exp_busy = 0;
            exp_ready = RST_READY;
`ifdef TILE_WRITER_CLEAR_ON_RESET_EN
            for (int a = 0; a < ROWS * COLS; a++) q.push_back(mk(a, BLANK, 1'b0));
`endif
            model_on = 1'b1;
        end else if (model_on) begin
            exp_err = 0;
            if (cmd_valid && exp_ready) begin
                acc_cnt++;
                m_r = int'(cmd_row);
                m_c = int'(cmd_col);
                case (cmd_op)
                    2'd0: if (m_r >= ROWS || m_c >= COLS) exp_err = 1;
                          else q.push_back(mk(m_r * COLS + m_c, cmd_data, 1'b1));
                    2'd1: for (int a = 0; a < ROWS * COLS; a++)
                              q.push_back(mk(a, cmd_data, a == ROWS * COLS - 1));
                    2'd2: if (m_r >= ROWS) exp_err = 1;
                          else for (int k = 0; k < COLS; k++)
                              q.push_back(mk(m_r * COLS + k, cmd_data, k == COLS - 1));
                    default: if (m_c >= COLS) exp_err = 1;
                          else for (int k = 0; k < ROWS; k++)
                              q.push_back(mk(k * COLS + m_c, cmd_data, k == ROWS - 1));
                endcase
            end
            if (q.size() > 0) begin
                wr_t w;
                w = q.pop_front();
                exp_we = 1; exp_addr = w.addr; exp_din = w.data; exp_done = w.last;
            end else begin
                exp_we = 0; exp_done = 0;
            end
            exp_ready = (q.size() == 0) && !exp_we;
            exp_busy  = !exp_ready;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("write_en", 32'(write_en), 32'(exp_we));
            check("done", 32'(done), 32'(exp_done));
            check("err", 32'(err), 32'(exp_err));
            check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
            check("busy", 32'(busy), 32'(exp_busy));
            if (exp_we || in_reset) begin
                check("waddr", 32'(waddr), 32'(exp_addr));
                check("din", 32'(din), 32'(exp_din));
            end
        end
    end

    // Holds the command valid until the model accepts it; returns on the first write cycle.
    task automatic send(input logic [1:0] op, input logic [4:0] r, input logic [5:0] c,
                        input logic [DW-1:0] d);
        int start;
        bit ok;
        start = acc_cnt;
        ok    = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_row = r; cmd_col = c; cmd_data = d;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (acc_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_row = 5'($urandom); cmd_col = 6'($urandom); cmd_data = 8'($urandom);
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_ready && q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    int n, first, last, done_at, ready_seen;
    logic [1:0] op;

    initial begin
        rstn = 1'b0; cmd_valid = 1'b0;
        cmd_op = '0; cmd_row = '0; cmd_col = '0; cmd_data = '0;
        repeat (3) @(negedge clk);
        check("rst_write_en", 32'(write_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'(RST_READY));
        rstn = 1'b1;

`ifdef TILE_WRITER_CLEAR_ON_RESET_EN
        // Command held valid across the clear; it must land only after address 1199.
        send(2'b00, 5'd1, 6'd1, 8'h5A);
        check("post_clear_addr", 32'(waddr), 32'd41);
        check("post_clear_din", 32'(din), 32'h5A);
        wait_idle();
`endif

        // Single write
        send(2'b00, 5'd2, 6'd5, 8'h3C);
        check("single_addr", 32'(waddr), 32'd85);
        check("single_din", 32'(din), 32'h3C);
        check("single_we", 32'(write_en), 32'd1);
        check("single_done", 32'(done), 32'd1);
        @(negedge clk);
        check("single_ready_after", 32'(cmd_ready), 32'd1);
        check("single_we_after", 32'(write_en), 32'd0);

        // Row fill of the last row
        send(2'b10, 5'd29, 6'd0, 8'h07);
        n = 0; first = -1; last = -1; done_at = 0;
        for (int i = 0; i < 45; i++) begin
            if (write_en) begin
                n++;
                if (first < 0) first = int'(waddr);
                last = int'(waddr);
                if (done) done_at = n;
            end
            @(negedge clk);
        end
        check("row_count", 32'(n), 32'd40);
        check("row_first", 32'(first), 32'd1160);
        check("row_last", 32'(last), 32'd1199);
        check("row_done_at", 32'(done_at), 32'd40);

        // Column fill of the last column
        send(2'b11, 5'd0, 6'd39, 8'h11);
        n = 0; first = -1; last = -1; ready_seen = 0;
        for (int i = 0; i < 35; i++) begin
            if (write_en) begin
                n++;
                if (first < 0) first = int'(waddr);
                last = int'(waddr);
                if (cmd_ready) ready_seen++;
            end
            @(negedge clk);
        end
        check("col_count", 32'(n), 32'd30);
        check("col_first", 32'(first), 32'd39);
        check("col_last", 32'(last), 32'd1199);
        check("col_ready_low", 32'(ready_seen), 32'd0);

        // Range errors and ignored fields
        send(2'b00, 5'd30, 6'd0, 8'h99);
        check("oor_err", 32'(err), 32'd1);
        check("oor_we", 32'(write_en), 32'd0);
        send(2'b10, 5'd5, 6'd63, 8'h22);
        check("row_ignore_col_err", 32'(err), 32'd0);
        check("row_ignore_col_addr", 32'(waddr), 32'd200);
        wait_idle();

        // Reset in the middle of a table fill
        send(2'b01, 5'd0, 6'd0, 8'hFF);
        repeat (99) @(negedge clk);
        check("fill_addr_100", 32'(waddr), 32'd99);
        rstn = 1'b0;
        @(negedge clk);
        check("abort_we", 32'(write_en), 32'd0);
        check("abort_waddr", 32'(waddr), 32'd0);
        check("abort_din", 32'(din), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'(RST_READY));
        @(negedge clk);
        rstn = 1'b1;
        send(2'b00, 5'd0, 6'd0, 8'hA5);
        check("after_abort_addr", 32'(waddr), 32'd0);
        check("after_abort_din", 32'(din), 32'hA5);

        // Random traffic, including back-to-back and out-of-range commands
        for (int t = 0; t < 60; t++) begin
            op = 2'($urandom_range(0, 3));
            if (op == 2'b01 && $urandom_range(0, 4) != 0) op = 2'b10;
            send(op, 5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)), 8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
